uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//   Buffered 8N1 UART transmitter that drives the serial line sampled by the
//   board-level UART monitor (uart_rtl_txd). Bytes from the SoC-side producer
//   are queued in a small FIFO, then shifted out LSB-first with one start bit
//   and one stop bit. The line idles high, and back-to-back frames stream
//   without software pacing.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per bit (100 MHz / 230400 baud); >= 2
//   FIFO_DEPTH    16   byte entries in the TX queue; power of two, >= 2
//   CNT_W         $clog2(FIFO_DEPTH)+1  width of fifo_count
// PORTS
//   clock       in   1      single system clock, rising edge
//   reset_rtl   in   1      asynchronous, active-low reset
//   tx_data     in   8      byte to enqueue
//   tx_valid    in   1      producer offers tx_data this cycle
//   tx_ready    out  1      FIFO can accept; transfer = tx_valid & tx_ready
//   txd         out  1      serial output, idle high
//   busy        out  1      high while a frame is on the line (START..STOP)
//   fifo_count  out  CNT_W  bytes queued (excludes the byte being shifted)
// BEHAVIOUR
//   Reset (reset_rtl=0, async): txd=1, tx_ready=1, busy=0, fifo_count=0,
//     FSM=IDLE, FIFO emptied. A reset mid-frame aborts it; txd goes high at once.
//   Handshake: tx_ready = !full (registered). A push while full is ignored.
//     Push and pop in the same cycle leave fifo_count unchanged. Pointers
//     wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, STOP. A bit counter runs
//     0..CLKS_PER_BIT-1, and a bit index runs 0..7.
//   IDLE: txd=1, busy=0. If the FIFO is non-empty, then at the next edge:
//     pop the head into the shift register, set txd=0, busy=1, go to START.
//   START: hold txd=0 for CLKS_PER_BIT cycles, then go to DATA with
//     txd=shift[0].
//   DATA: each bit is held for CLKS_PER_BIT cycles, LSB first. After bit 7,
//     go to STOP with txd=1.
//   STOP: hold txd=1 for CLKS_PER_BIT cycles, then go to IDLE with busy=0.
//   Latency: a byte pushed into an empty FIFO while IDLE at edge k has its
//     start bit begin at edge k+1.
//   Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are
//     separated by exactly 1 idle clock (txd=1).
//   Output rules: txd and busy are registered outputs with no combinational
//     path from inputs. tx_data is captured only on a transfer.
// STRUCTURE
//   uart_pkg: state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2,
//     STOP=2'd3) and the default CLKS_PER_BIT constant.
//   Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push, pop, full, empty
//     and count, with the same clock and reset. The FSM and shift/bit
//     counters live in the top level.
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//   1 Reset release, no traffic -> txd=1, busy=0, tx_ready=1 and fifo_count=0
//     held for 100 cycles.
//   2 Push 0x55 once -> txd low 4 clk, then bits 1,0,1,0,1,0,1,0 (4 clk
//     each), then high 4 clk. Frame = 40 clk; busy low after the frame.
//   3 Push 0x41,0x42,0x43 back-to-back -> monitor decodes "ABC". Idle gap
//     between frames is exactly 1 clk.
//   4 Hold tx_valid for 6 bytes while the line is busy -> tx_ready drops at
//     fifo_count=4, the extra push is dropped, and exactly 5 bytes are sent
//     (1 in flight + 4 queued).
//   5 Assert reset_rtl=0 mid DATA of 0xA5 -> txd=1 the same cycle, FIFO
//     empty, and after release no residual frame is emitted.
//   6 CLKS_PER_BIT=434, push 0x0A -> the 230400-baud monitor receives 0x0A
//     and data_valid pulses once.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module : uart_pkg
//  Brief  : Shared state encoding and default bit timing for the UART TX.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_buffered_if.sv
// ============================================================================
//  Module : uart_tx_buffered_if
//  Brief  : Valid/ready byte channel from the SoC producer into the TX queue.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_buffered_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module : sync_fifo
//  Brief  : Single-clock FIFO with registered full/empty flags and count.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clock,
    input  wire logic             reset_rtl,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic      [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] next_count;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        next_count = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_rtl) begin
        if (!reset_rtl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;
            full  <= (next_count == CNT_W'(DEPTH));
            empty <= (next_count == '0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
//  Module : uart_tx_buffered
//  Brief  : FIFO-buffered 8N1 UART transmitter, LSB first, idle-high line.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  wire logic             clock,
    input  wire logic             reset_rtl,
    uart_tx_buffered_if.slave     tx_bus,
    output logic                  txd,
    output logic                  busy,
    output logic      [CNT_W-1:0] fifo_count
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          fifo_pop;

    assign tx_bus.tx_ready = !full;
    assign fifo_pop        = (state == IDLE) && !empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset_rtl (reset_rtl),
        .push      (tx_bus.tx_valid),
        .push_data (tx_bus.tx_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // txd always carries the bit of the state being entered, so each bit
    // lasts exactly CLKS_PER_BIT cycles and frames are 10 bit-times long.
    always_ff @(posedge clock or negedge reset_rtl) begin
        if (!reset_rtl) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!empty) begin
                        shift <= head;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        txd     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
//  Module : tb_uart_tx_buffered
//  Brief  : Directed self-checking bench for the buffered UART transmitter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int CPB_S  = 434;

    logic          clock = 1'b0;
    logic          reset_rtl = 1'b0;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          txd_slow;
    logic          busy_slow;
    logic [4:0]    fifo_count_slow;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_tx_buffered_if bus ();
    uart_tx_buffered_if bus_slow ();

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset_rtl  (reset_rtl),
        .tx_bus     (bus),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB_S), .FIFO_DEPTH(16), .CNT_W(5)) dut_slow (
        .clock      (clock),
        .reset_rtl  (reset_rtl),
        .tx_bus     (bus_slow),
        .txd        (txd_slow),
        .busy       (busy_slow),
        .fifo_count (fifo_count_slow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits in time order: bit0 = start, bit9 = stop
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Sample txd/busy mid-cycle for n cycles, starting with the cycle after the next edge.
    task automatic capture(input int n, output logic [255:0] v, output logic [255:0] b);
        v = '1;
        b = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            @(negedge clock);
            v[c] = txd;
            b[c] = busy;
        end
    endtask

    function automatic logic [255:0] build(input logic [63:0] bytes, input int n);
        logic [255:0] v;
        logic [9:0]   f;
        int           pos;
        v   = '1;
        pos = 0;
        for (int j = 0; j < n; j++) begin
            f = {1'b1, bytes[8*j +: 8], 1'b0};
            for (int k = 0; k < 10; k++) begin
                for (int r = 0; r < CPB; r++) begin
                    v[pos] = f[k];
                    pos++;
                end
            end
            pos++;
        end
        return v;
    endfunction

    // Mid-bit sampling receiver over a captured line trace.
    function automatic void decode(input logic [255:0] v, input int n,
                                   output logic [63:0] bytes, output int cnt);
        int c;
        bytes = '0;
        cnt   = 0;
        c     = 0;
        while (c + 10 * CPB <= n) begin
            if (v[c] == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    bytes[8*cnt + i] = v[c + CPB/2 + CPB*(i+1)];
                end
                if (v[c + CPB/2 + CPB*9] == 1'b1 && cnt < 8) cnt++;
                c += 10 * CPB;
            end else begin
                c++;
            end
        end
    endfunction

    task automatic push_one(input logic [7:0] d);
        @(negedge clock);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    // Serial monitor for the full-rate instance: data_valid pulses per good frame.
    logic [7:0] mon_byte  = '0;
    logic       mon_valid = 1'b0;
    int         mon_count = 0;

    initial begin
        logic [7:0] rx;
        forever begin
            @(negedge txd_slow);
            repeat (CPB_S / 2) @(posedge clock);
            if (txd_slow == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB_S) @(posedge clock);
                    rx[i] = txd_slow;
                end
                repeat (CPB_S) @(posedge clock);
                if (txd_slow == 1'b1) begin
                    mon_byte  = rx;
                    mon_valid = 1'b1;
                    mon_count++;
                    @(posedge clock);
                    mon_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [255:0] gv, gb, ev, eb;
        logic [63:0]  dec;
        int           ncnt;
        logic         ok;

        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'hA5, frame: 10'h34A};
        vecs[4] = '{data: 8'h41, frame: 10'h282};

        bus.tx_data       = '0;
        bus.tx_valid      = 1'b0;
        bus_slow.tx_data  = '0;
        bus_slow.tx_valid = 1'b0;

        // Reset values while held, then 100 quiet cycles after release
        repeat (3) @(negedge clock);
        check("reset_txd", 256'(txd), 256'(1));
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_ready", 256'(bus.tx_ready), 256'(1));
        check("reset_count", 256'(fifo_count), 256'(0));
        reset_rtl = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (txd !== 1'b1 || busy !== 1'b0 || bus.tx_ready !== 1'b1 || fifo_count !== '0)
                ok = 1'b0;
        end
        check("idle_hold_100", 256'(ok), 256'(1));

        // Single frames from the vector table
        foreach (vecs[i]) begin
            push_one(vecs[i].data);
            check("push_count", 256'(fifo_count), 256'(1));
            check("pre_start_txd", 256'(txd), 256'(1));
            ev = '1;
            eb = '0;
            for (int c = 0; c < 10 * CPB; c++) begin
                ev[c] = vecs[i].frame[c / CPB];
                eb[c] = 1'b1;
            end
            capture(10 * CPB + 1, gv, gb);
            check("frame_txd", gv & ((256'(1) << 41) - 1), ev & ((256'(1) << 41) - 1));
            check("frame_busy", gb, eb);
            check("post_count", 256'(fifo_count), 256'(0));
        end

        // Three back-to-back bytes: "ABC" with single idle clocks between frames
        push_one(8'h41);
        fork
            begin
                bus.tx_data = 8'h42; bus.tx_valid = 1'b1;
                @(posedge clock); #1;
                bus.tx_data = 8'h43;
                @(posedge clock); #1;
                bus.tx_valid = 1'b0;
            end
            capture(125, gv, gb);
        join
        ev = build(64'h434241, 3);
        check("abc_stream", gv & ((256'(1) << 125) - 1), ev & ((256'(1) << 125) - 1));
        decode(gv, 125, dec, ncnt);
        check("abc_nframes", 256'(ncnt), 256'(3));
        check("abc_bytes", 256'(dec), 256'(64'h434241));

        // Overfill: six offers, the sixth meets a full queue and is dropped
        repeat (5) @(negedge clock);
        push_one(8'h60);
        fork
            begin
                for (int j = 1; j < 6; j++) begin
                    if (j == 5) begin
                        check("full_ready", 256'(bus.tx_ready), 256'(0));
                        check("full_count", 256'(fifo_count), 256'(4));
                    end
                    bus.tx_data  = 8'h60 + 8'(j);
                    bus.tx_valid = 1'b1;
                    @(posedge clock); #1;
                end
                bus.tx_valid = 1'b0;
            end
            capture(220, gv, gb);
        join
        ev = build(64'h6463626160, 5);
        check("overfill_stream", gv & ((256'(1) << 220) - 1), ev & ((256'(1) << 220) - 1));
        decode(gv, 220, dec, ncnt);
        check("overfill_nframes", 256'(ncnt), 256'(5));
        check("overfill_count_end", 256'(fifo_count), 256'(0));
        check("overfill_ready_end", 256'(bus.tx_ready), 256'(1));

        // Reset in the middle of a 0xA5 data phase with another byte queued
        repeat (5) @(negedge clock);
        push_one(8'hA5);
        push_one(8'h11);
        repeat (16) @(posedge clock);
        #3;
        check("pre_abort_busy", 256'(busy), 256'(1));
        reset_rtl = 1'b0;
        #1;
        check("abort_txd", 256'(txd), 256'(1));
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_count", 256'(fifo_count), 256'(0));
        check("abort_ready", 256'(bus.tx_ready), 256'(1));
        repeat (2) @(negedge clock);
        reset_rtl = 1'b1;
        capture(100, gv, gb);
        check("no_residual_txd", gv & ((256'(1) << 100) - 1), (256'(1) << 100) - 1);
        check("no_residual_busy", gb, 256'(0));

        // Full-rate timing on the 434-clock instance
        @(negedge clock);
        bus_slow.tx_data  = 8'h0A;
        bus_slow.tx_valid = 1'b1;
        @(posedge clock); #1;
        bus_slow.tx_valid = 1'b0;
        repeat (10 * CPB_S + 200) @(posedge clock);
        check("baud_rx_count", 256'(mon_count), 256'(1));
        check("baud_rx_byte", 256'(mon_byte), 256'(8'h0A));
        repeat (1000) @(posedge clock);
        #1;
        check("baud_single_valid", 256'(mon_count), 256'(1));
        check("baud_idle_txd", 256'(txd_slow), 256'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
